// File: rtl/dual_issue_sched_pkg.sv
// Shared definitions for the dual-issue scheduler: MIPS opcodes, field slices,
// the instruction-class enum and the buffered-entry record.
package dual_issue_sched_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } instr_class_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    function automatic logic is_mem(input instr_class_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

    function automatic logic is_ctl(input instr_class_e c);
        return (c == CLS_BRANCH) || (c == CLS_JUMP);
    endfunction

endpackage

// File: rtl/dual_issue_sched_decode.sv
// Classifies one instruction and extracts its register usage; register 0 is
// reported as "no destination" / "unused source" so it never forms a dependency.
module instr_class_decode
    import dual_issue_sched_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e cls_o,
    output logic [4:0]   dest_o,
    output logic [4:0]   src_a_o,
    output logic [4:0]   src_b_o,
    output logic         uses_a_o,
    output logic         uses_b_o
);
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       use_a, use_b;

    assign op = instr_i[OP_MSB:OP_LSB];
    assign rs = instr_i[RS_MSB:RS_LSB];
    assign rt = instr_i[RT_MSB:RT_LSB];
    assign rd = instr_i[RD_MSB:RD_LSB];

    // Anything not listed is an ALU-immediate form writing rt.
    always_comb begin
        cls_o  = CLS_ALU;
        dest_o = rt;
        use_a  = 1'b1;
        use_b  = 1'b0;
        case (op)
            OP_RTYPE: begin dest_o = rd; use_b = 1'b1; end
            OP_LW:    cls_o = CLS_LOAD;
            OP_SW:    begin cls_o = CLS_STORE; dest_o = 5'd0; use_b = 1'b1; end
            OP_BEQ,
            OP_BNE:   begin cls_o = CLS_BRANCH; dest_o = 5'd0; use_b = 1'b1; end
            OP_J:     begin cls_o = CLS_JUMP; dest_o = 5'd0; use_a = 1'b0; end
            OP_JAL:   begin cls_o = CLS_JUMP; dest_o = REG_RA; use_a = 1'b0; end
            default:  ;
        endcase
    end

    assign src_a_o  = rs;
    assign src_b_o  = rt;
    assign uses_a_o = use_a && (rs != 5'd0);
    assign uses_b_o = use_b && (rt != 5'd0);

endmodule

// File: rtl/dual_issue_sched.sv
// In-order dual-issue scheduler: a circular pair-fetch buffer feeding a
// registered two-slot issue stage with RAW/WAW, memory-port and load-use checks.
module dual_issue_sched
    import dual_issue_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [31:0]              fetch_instr0,
    input  logic [31:0]              fetch_instr1,
    input  logic [31:0]              fetch_pc,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     issue0_valid,
    output logic [31:0]              issue0_instr,
    output logic [31:0]              issue0_pc,
    output logic                     issue1_valid,
    output logic [31:0]              issue1_instr,
    output logic [31:0]              issue1_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          buf_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            iv0_q, iv0_d, iv1_q, iv1_d;
    entry_t          is0_q, is0_d, is1_q, is1_d;
    logic [4:0]      lu0_q, lu0_d, lu1_q, lu1_d;

    entry_t          head0, head1;
    instr_class_e    cls0, cls1;
    logic [4:0]      dest0, dest1, sa0, sb0, sa1, sb1;
    logic            ua0, ub0, ua1, ub1;
    logic            hz0, hz1, can0, can1, enq;
    logic [1:0]      deq_cnt;

    // Handshake: a pair transfers on a cycle where fetch_valid and fetch_ready
    // are both high and flush is low; fetch_ready depends only on registered count.
    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(2);
    assign enq         = fetch_valid && fetch_ready && !flush;

    assign head0 = buf_q[rd_ptr_q];
    assign head1 = buf_q[rd_ptr_q + PW'(1)];

    instr_class_decode u_dec0 (
        .instr_i (head0.instr), .cls_o (cls0), .dest_o (dest0),
        .src_a_o (sa0), .src_b_o (sb0), .uses_a_o (ua0), .uses_b_o (ub0)
    );

    instr_class_decode u_dec1 (
        .instr_i (head1.instr), .cls_o (cls1), .dest_o (dest1),
        .src_a_o (sa1), .src_b_o (sb1), .uses_a_o (ua1), .uses_b_o (ub1)
    );

    // lu*_q hold the load destinations of the bundle currently on the issue outputs.
    assign hz0 = (ua0 && (sa0 == lu0_q || sa0 == lu1_q)) ||
                 (ub0 && (sb0 == lu0_q || sb0 == lu1_q));
    assign hz1 = (ua1 && (sa1 == lu0_q || sa1 == lu1_q)) ||
                 (ub1 && (sb1 == lu0_q || sb1 == lu1_q));

    assign can0 = (count_q != '0) && !hz0;
    assign can1 = can0 && (count_q >= CW'(2)) &&
                  !(ua1 && sa1 == dest0) && !(ub1 && sb1 == dest0) &&
                  !(dest1 != 5'd0 && dest1 == dest0) &&
                  !(is_mem(cls0) && is_mem(cls1)) &&
                  !is_ctl(cls1) && !hz1;

    assign deq_cnt = stall ? 2'd0 : ({1'b0, can0} + {1'b0, can1});

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        iv0_d    = iv0_q;
        iv1_d    = iv1_q;
        is0_d    = is0_q;
        is1_d    = is1_q;
        lu0_d    = lu0_q;
        lu1_d    = lu1_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            iv0_d    = 1'b0;
            iv1_d    = 1'b0;
            is0_d    = '0;
            is1_d    = '0;
            lu0_d    = 5'd0;
            lu1_d    = 5'd0;
        end else begin
            if (!stall) begin
                iv0_d    = can0;
                iv1_d    = can1;
                is0_d    = can0 ? head0 : '0;
                is1_d    = can1 ? head1 : '0;
                lu0_d    = (can0 && cls0 == CLS_LOAD) ? dest0 : 5'd0;
                lu1_d    = (can1 && cls1 == CLS_LOAD) ? dest1 : 5'd0;
                rd_ptr_d = rd_ptr_q + PW'(deq_cnt);
            end
            if (enq) wr_ptr_d = wr_ptr_q + PW'(2);
            count_d = count_q + (enq ? CW'(2) : CW'(0)) - CW'(deq_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            iv0_q    <= 1'b0;
            iv1_q    <= 1'b0;
            is0_q    <= '0;
            is1_q    <= '0;
            lu0_q    <= 5'd0;
            lu1_q    <= 5'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            iv0_q    <= iv0_d;
            iv1_q    <= iv1_d;
            is0_q    <= is0_d;
            is1_q    <= is1_d;
            lu0_q    <= lu0_d;
            lu1_q    <= lu1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            buf_q[wr_ptr_q]          <= '{instr: fetch_instr0, pc: fetch_pc};
            buf_q[wr_ptr_q + PW'(1)] <= '{instr: fetch_instr1, pc: fetch_pc + 32'd4};
        end
    end

    assign count        = count_q;
    assign issue0_valid = iv0_q;
    assign issue0_instr = is0_q.instr;
    assign issue0_pc    = is0_q.pc;
    assign issue1_valid = iv1_q;
    assign issue1_instr = is1_q.instr;
    assign issue1_pc    = is1_q.pc;

endmodule

// File: tb/tb_dual_issue_sched.sv
// Bench for dual_issue_sched: directed scenarios plus random traffic, every
// cycle compared against a queue-based model of the issue rules.
module tb_dual_issue_sched;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset, fetch_valid, fetch_ready, stall, flush;
    logic [31:0] fetch_instr0, fetch_instr1, fetch_pc;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue0_pc, issue1_instr, issue1_pc;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_err = 0;

    // Model state: buffered {instr, pc} entries and expected registered outputs.
    logic [63:0] exp_q[$];
    logic        e_v0, e_v1, e_ready;
    logic [31:0] e_i0, e_p0, e_i1, e_p1;
    logic [4:0]  m_lu0, m_lu1;

    dual_issue_sched #(.DEPTH(DEPTH)) dut (
        .clk (clk), .reset (reset), .fetch_valid (fetch_valid), .fetch_ready (fetch_ready),
        .fetch_instr0 (fetch_instr0), .fetch_instr1 (fetch_instr1), .fetch_pc (fetch_pc),
        .stall (stall), .flush (flush),
        .issue0_valid (issue0_valid), .issue0_instr (issue0_instr), .issue0_pc (issue0_pc),
        .issue1_valid (issue1_valid), .issue1_instr (issue1_instr), .issue1_pc (issue1_pc),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input int rd, input int rs, input int rt, input int fn);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rt, input int rs, input int imm);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
    endfunction

    function automatic int m_op(input logic [31:0] ins);
        return int'(ins >> 26);
    endfunction

    function automatic logic [4:0] m_dest(input logic [31:0] ins);
        int op = m_op(ins);
        if (op == 0) return ins[15:11];
        if (op == 'h2B || op == 4 || op == 5 || op == 2) return 5'd0;
        if (op == 3) return 5'd31;
        return ins[20:16];
    endfunction

    function automatic bit m_reads(input logic [31:0] ins, input logic [4:0] r);
        int op = m_op(ins);
        if (r == 0 || op == 2 || op == 3) return 0;
        if (ins[25:21] == r) return 1;
        if ((op == 0 || op == 'h2B || op == 4 || op == 5) && ins[20:16] == r) return 1;
        return 0;
    endfunction

    function automatic bit m_mem(input logic [31:0] ins);
        return m_op(ins) == 'h23 || m_op(ins) == 'h2B;
    endfunction

    function automatic bit m_ctl(input logic [31:0] ins);
        int op = m_op(ins);
        return op >= 2 && op <= 5;
    endfunction

    function automatic bit m_hazard(input logic [31:0] ins);
        return m_reads(ins, m_lu0) || m_reads(ins, m_lu1);
    endfunction

    task automatic model_step(input bit fv, input logic [31:0] i0, input logic [31:0] i1,
                              input logic [31:0] pc, input bit st, input bit fl, input bit rs);
        bit t0, t1, rdy;
        logic [31:0] a, b;
        t0 = 0; t1 = 0; a = '0; b = '0;
        if (rs || fl) begin
            exp_q.delete();
            {e_v0, e_v1, e_i0, e_p0, e_i1, e_p1} = '0;
            m_lu0 = 0; m_lu1 = 0;
        end else begin
            rdy = exp_q.size() <= DEPTH - 2;
            if (!st) begin
                if (exp_q.size() >= 1) begin a = exp_q[0][63:32]; t0 = !m_hazard(a); end
                if (t0 && exp_q.size() >= 2) begin
                    b = exp_q[1][63:32];
                    t1 = !m_reads(b, m_dest(a)) && !(m_dest(b) != 0 && m_dest(b) == m_dest(a)) &&
                         !(m_mem(a) && m_mem(b)) && !m_ctl(b) && !m_hazard(b);
                end
                e_v0 = t0; e_i0 = t0 ? a : 0; e_p0 = t0 ? exp_q[0][31:0] : 0;
                e_v1 = t1; e_i1 = t1 ? b : 0; e_p1 = t1 ? exp_q[1][31:0] : 0;
                m_lu0 = (t0 && m_op(a) == 'h23) ? m_dest(a) : 5'd0;
                m_lu1 = (t1 && m_op(b) == 'h23) ? m_dest(b) : 5'd0;
                if (t0) void'(exp_q.pop_front());
                if (t1) void'(exp_q.pop_front());
            end
            if (fv && rdy) begin
                exp_q.push_back({i0, pc});
                exp_q.push_back({i1, pc + 32'd4});
            end
        end
        e_ready = exp_q.size() <= DEPTH - 2;
    endtask

    task automatic step(input bit fv, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input bit st, input bit fl, input bit rs);
        @(negedge clk);
        fetch_valid = fv; fetch_instr0 = i0; fetch_instr1 = i1; fetch_pc = pc;
        stall = st; flush = fl; reset = rs;
        model_step(fv, i0, i1, pc, st, fl, rs);
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(exp_q.size()));
        check("fetch_ready", 32'(fetch_ready), 32'(e_ready));
        check("issue0_valid", 32'(issue0_valid), 32'(e_v0));
        check("issue1_valid", 32'(issue1_valid), 32'(e_v1));
        check("issue0_instr", issue0_instr, e_i0);
        check("issue0_pc", issue0_pc, e_p0);
        check("issue1_instr", issue1_instr, e_i1);
        check("issue1_pc", issue1_pc, e_p1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        int rd = $urandom_range(0, 7);
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        case ($urandom_range(0, 7))
            0, 1: return r_type(rd, rs, rt, 'h20);
            2:    return i_type('h08, rt, rs, 5);
            3:    return i_type('h23, rt, rs, 0);
            4:    return i_type('h2B, rt, rs, 4);
            5:    return i_type($urandom_range(4, 5), rt, rs, 2);
            6:    return i_type('h02, 0, 0, 16);
            default: return i_type('h03, 0, 0, 32);
        endcase
    endfunction

    initial begin
        reset = 1; fetch_valid = 0; fetch_instr0 = 0; fetch_instr1 = 0; fetch_pc = 0;
        stall = 0; flush = 0;
        m_lu0 = 0; m_lu1 = 0;
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Independent pair at pc 0: both slots in the cycle after buffering.
        step(1, r_type(1, 2, 3, 'h20), r_type(4, 5, 6, 'h22), 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("indep_v0", 32'(issue0_valid), 1);
        check("indep_v1", 32'(issue1_valid), 1);
        check("indep_pc1", issue1_pc, 32'h4);
        idle(3);

        step(1, r_type(1, 2, 3, 'h20), r_type(4, 1, 5, 'h20), 32'h100, 0, 0, 0);
        idle(4);
        step(1, i_type('h23, 2, 1, 0), 32'h0, 32'h200, 0, 0, 0);
        step(1, r_type(3, 2, 2, 'h20), 32'h0, 32'h208, 0, 0, 0);
        idle(5);
        step(1, i_type('h23, 1, 2, 0), i_type('h2B, 3, 4, 0), 32'h300, 0, 0, 0);
        idle(4);
        step(1, i_type('h04, 2, 1, 8), r_type(5, 6, 7, 'h20), 32'h400, 0, 0, 0);
        idle(4);

        // Fill under stall, then drain.
        step(1, r_type(1, 2, 3, 'h20), r_type(4, 5, 6, 'h20), 32'h500, 1, 0, 0);
        step(1, r_type(7, 1, 4, 'h20), r_type(2, 3, 3, 'h20), 32'h508, 1, 0, 0);
        check("full_count", 32'(count), 4);
        check("full_ready", 32'(fetch_ready), 0);
        idle(6);

        // Flush beats stall and drops the same-cycle fetch.
        step(1, r_type(1, 2, 3, 'h20), r_type(4, 5, 6, 'h20), 32'h600, 1, 0, 0);
        step(1, r_type(1, 2, 3, 'h20), r_type(4, 5, 6, 'h20), 32'h608, 1, 1, 0);
        check("flush_count", 32'(count), 0);
        check("flush_v0", 32'(issue0_valid), 0);
        check("flush_v1", 32'(issue1_valid), 0);
        idle(2);

        for (int c = 0; c < 2500; c++) begin
            logic [31:0] pc;
            pc = 32'($urandom_range(0, 32'hFFFF)) << 3;
            step($urandom_range(0, 9) < 7, rand_instr(), rand_instr(), pc,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) == 0);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dual_issue_sched.md
DUAL_ISSUE_SCHED -- requirements
Module: dual_issue_sched

Interface
REQ-001 Parameter: DEPTH, 4, instruction buffer entries (power of two, at least 4).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: fetch_valid  input  1  fetch presents an instruction pair.
REQ-005 Port: fetch_ready  output  1  buffer can accept a pair this cycle.
REQ-006 Port: fetch_instr0 / fetch_instr1  input  32 each  older / younger MIPS instruction.
REQ-007 Port: fetch_pc  input  32  PC of fetch_instr0; fetch_instr1 is at fetch_pc+4.
REQ-008 Port: stall  input  1  downstream pipeline frozen.
REQ-009 Port: flush  input  1  taken-branch redirect; discard all buffered work.
REQ-010 Port: issue0_valid, issue0_instr, issue0_pc  output  1/32/32  slot 0 (all classes).
REQ-011 Port: issue1_valid, issue1_instr, issue1_pc  output  1/32/32  slot 1 (ALU and memory only).
REQ-012 Port: count  output  clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-013 The buffer SHALL be a circular FIFO storing {instr, pc} per entry.
REQ-014 fetch_ready SHALL be 1 when free entries >= 2, computed from registered occupancy only.
REQ-015 Enqueue SHALL occur when fetch_valid & fetch_ready & ~flush, writing two entries, instr0 first.
REQ-016 Enqueue and dequeue in the same cycle SHALL both take effect; count SHALL update by (+2 enq) - (issued).
REQ-017 Issue outputs SHALL be registered; a pair enqueued in cycle N SHALL issue no earlier than cycle N+1.
REQ-018 Decode SHALL use op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
REQ-019 Destination SHALL be: rd for op=0; rt for ALU-immediate and loads (op 0x23); none for stores (op 0x2B), branches (0x04, 0x05) and j (0x02); $31 for jal (0x03).
REQ-020 Register 0 SHALL never create a dependency.
REQ-021 Sources SHALL be: rs for all ops except j/jal; rt additionally for op=0, stores and beq/bne.
REQ-022 Slot 0 SHALL take the oldest entry unless a load-use hazard exists: the previous issued cycle contained a load whose destination is a source of the oldest entry.
REQ-023 On a load-use hazard the block SHALL issue nothing for exactly one cycle, then issue normally.
REQ-024 Slot 1 SHALL take the second-oldest entry only if slot 0 issues and all of the following hold: the entry exists; it reads no slot-0 destination; it writes no slot-0 destination; it and slot 0 are not both memory ops; it is not a branch or jump; it has no load-use hazard.
REQ-025 A branch in slot 0 SHALL be allowed to pair with its delay-slot instruction in slot 1 under REQ-024.
REQ-026 Issue order SHALL be strictly in order; slot 1 never bypasses a blocked slot 0.
REQ-027 While stall=1, issue outputs and load-use state SHALL hold, nothing SHALL dequeue, and enqueue SHALL remain permitted.
REQ-028 flush=1 SHALL empty the buffer, drop same-cycle fetch, clear the load-use state and deassert both issue valids next cycle; flush SHALL have priority over stall.
REQ-029 Pointer wrap-around at DEPTH SHALL be seamless; count SHALL never exceed DEPTH.

Reset
REQ-030 On reset: count=0, pointers=0, issue0_valid=issue1_valid=0, issue instr/pc=0, load-use state cleared, fetch_ready=1 from the next cycle.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries, with the same priority as flush.

Structure
REQ-032 A shared package SHALL hold opcode constants, the instruction-class enum (ALU, LOAD, STORE, BRANCH, JUMP) and field-slice constants.
REQ-033 One sub-module, instr_class_decode, SHALL map an instruction to {class, dest, src_a, src_b, uses_a, uses_b}; it is instantiated twice.

Verification
REQ-034 Independent pair add $1,$2,$3 / sub $4,$5,$6 at pc=0x0 -> next cycle both valid, pcs 0x0 and 0x4.
REQ-035 RAW pair add $1,$2,$3 / add $4,$1,$5 -> add $1 alone in cycle 1, add $4 alone in slot 0 in cycle 2.
REQ-036 Load-use lw $2,0($1) / nop, then add $3,$2,$2 -> lw issues, one empty cycle follows, then add issues.
REQ-037 Two memory ops lw / sw -> issued serially; beq / delay-slot add -> paired.
REQ-038 Fill with 2 pairs (DEPTH=4) under stall=1 -> fetch_ready=0, count=4; release stall -> drains in order, pointers wrap correctly.
REQ-039 flush asserted together with stall and fetch_valid -> next cycle count=0, both issue valids 0, fetched pair dropped.
